// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_AW = 32;
    localparam int unsigned DEF_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between fetch and data requesters.
// Optional fetch starvation guard enabled by MEM_ARBITER_STARVE_GUARD_EN:
// after MAX_STREAK data grants issued while fetch waits, fetch wins once.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic grant_en,
    input  logic if_req,
    input  logic dm_req,
    output logic if_win,
    output logic dm_win
);

`ifdef MEM_ARBITER_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    logic [SW-1:0] streak_q, streak_d;
    logic          fetch_turn;

    // Data wins unless fetch has waited through a full streak of data grants.
    always_comb begin
        fetch_turn = (streak_q == STREAK_MAX);
        dm_win     = grant_en && dm_req && !(if_req && fetch_turn);
        if_win     = grant_en && if_req && !dm_win;
        streak_d   = streak_q;
        if (if_win) begin
            streak_d = '0;
        end else if (dm_win) begin
            streak_d = if_req ? streak_q + SW'(1) : '0;
        end
    end

    // Streak counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    logic unused_prio;
    assign unused_prio = &{1'b0, clk, reset, MAX_STREAK[0]};

    // Strict data-over-fetch priority.
    always_comb begin
        dm_win = grant_en && dm_req;
        if_win = grant_en && if_req && !dm_req;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single memory port.
// One access in flight: grant (IDLE) -> mem_en (ACCESS) -> wait MEM_LAT (RESP).
// Optional fetch starvation guard: MEM_ARBITER_STARVE_GUARD_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = DEF_AW,
    parameter int unsigned DW         = DEF_DW,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          if_win, dm_win;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;

    // Grants are suppressed while reset is held so they read 0 immediately.
    mem_arb_prio #(
        .MAX_STREAK(MAX_STREAK)
    ) u_prio (
        .clk      (clk),
        .reset    (reset),
        .grant_en ((state_q == IDLE) && !reset),
        .if_req   (if_req),
        .dm_req   (dm_req),
        .if_win   (if_win),
        .dm_win   (dm_win)
    );

    // Next-state, request latching and response outputs.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rsp_valid = 1'b0;
        mem_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (dm_win) begin
                    owner_d = OWN_DM;
                    addr_d  = dm_addr;
                    we_d    = dm_we;
                    wdata_d = dm_wdata;
                    state_d = ACCESS;
                end else if (if_win) begin
                    owner_d = OWN_IF;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_en  = 1'b1;
                cnt_d   = LAT_INIT;
                state_d = RESP;
            end
            RESP: begin
                if (cnt_q == CW'(1)) begin
                    rsp_valid = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if_gnt     = if_win;
        dm_gnt     = dm_win;
        mem_we     = mem_en && we_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        rsp_data   = we_q ? '0 : mem_rdata;
        if_rvalid  = rsp_valid && (owner_q == OWN_IF);
        dm_rvalid  = rsp_valid && (owner_q == OWN_DM);
        // rdata passes memory data through on the pulse and holds it afterwards.
        if_rdata_d = if_rvalid ? rsp_data : if_rdata_q;
        dm_rdata_d = dm_rvalid ? rsp_data : dm_rdata_q;
        if_rdata   = if_rdata_d;
        dm_rdata   = dm_rdata_d;
    end

    // State, latched request and held read data registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 with MEM_LAT=1, instance 1 with MEM_LAT=3.
module tb_mem_arbiter;

    localparam int unsigned MAXS = 4;
    localparam logic        Y = 1'b1;
    localparam logic        N = 1'b0;
    localparam logic [31:0] Z = '0;
    localparam logic [31:0] IF0 = 32'hA5A5_0004;
    localparam logic [31:0] IF1 = 32'hA5A5_0008;
    localparam logic [31:0] D40 = 32'hA5A5_0010;
    localparam logic [31:0] D00 = 32'hA5A5_0000;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        if_req [2], if_gnt [2], if_rvalid [2];
    logic [31:0] if_addr [2], if_rdata [2];
    logic        dm_req [2], dm_we [2], dm_gnt [2], dm_rvalid [2];
    logic [31:0] dm_addr [2], dm_wdata [2], dm_rdata [2];
    logic        mem_en [2], mem_we [2];
    logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];
    logic        mem_clr;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [31:0] init_word(input logic [5:0] k);
        return 32'hA5A5_0000 | {26'h0, k};
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : 3;
        logic [31:0] mem_arr [64];
        logic [63:0] wr_v;
        logic [31:0] pipe [L];

        mem_arbiter #(
            .AW(32), .DW(32), .MEM_LAT(L), .MAX_STREAK(MAXS)
        ) u_dut (
            .clk(clk), .reset(rst[g]),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]),
            .dm_wdata(dm_wdata[g]), .dm_gnt(dm_gnt[g]), .dm_rvalid(dm_rvalid[g]),
            .dm_rdata(dm_rdata[g]), .mem_en(mem_en[g]), .mem_we(mem_we[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );

        // External memory: read data appears L cycles after the mem_en cycle.
        always @(posedge clk) begin
            if (mem_clr) begin
                wr_v <= '0;
            end else if (mem_en[g] && mem_we[g]) begin
                wr_v[mem_addr[g][7:2]]    <= 1'b1;
                mem_arr[mem_addr[g][7:2]] <= mem_wdata[g];
            end
            if (mem_en[g] && !mem_we[g])
                pipe[0] <= wr_v[mem_addr[g][7:2]] ? mem_arr[mem_addr[g][7:2]]
                                                  : init_word(mem_addr[g][7:2]);
            else
                pipe[0] <= 32'hBAD0_BAD0;
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[g] = pipe[L-1];
    end

    // Transaction-level reference model state.
    logic [31:0] ref_mem [2][64];
    int          cyc [2], free_at [2], en_at [2], rv_at [2], streak [2];
    logic        e_dm [2], e_we [2];
    logic [31:0] e_addr [2], e_wdata [2], e_data [2], x_ifd [2], x_dmd [2];
    logic        last_ig [2], last_dg [2];

    task automatic chk(input int i, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL u%0d %s: got %h, want %h", i, name, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        cyc[i] = 0; free_at[i] = 0; en_at[i] = -100; rv_at[i] = -100;
        x_ifd[i] = '0; x_dmd[i] = '0; streak[i] = 0;
    endtask

    // Called at negedge: predicts this cycle's outputs from the current requests.
    task automatic model_check(input int i);
        int   c;
        logic eg_if, eg_dm, guard;
        c = cyc[i]; eg_if = 1'b0; eg_dm = 1'b0; guard = 1'b0;
        if (c >= free_at[i] && (if_req[i] || dm_req[i])) begin
`ifdef MEM_ARBITER_STARVE_GUARD_EN
            guard = if_req[i] && (streak[i] >= MAXS);
`endif
            eg_dm = dm_req[i] && !guard;
            eg_if = !eg_dm;
            e_dm[i]    = eg_dm;
            e_addr[i]  = eg_dm ? dm_addr[i] : if_addr[i];
            e_we[i]    = eg_dm && dm_we[i];
            e_wdata[i] = eg_dm ? dm_wdata[i] : '0;
            if (e_we[i]) begin
                ref_mem[i][e_addr[i][7:2]] = e_wdata[i];
                e_data[i] = '0;
            end else begin
                e_data[i] = ref_mem[i][e_addr[i][7:2]];
            end
            if (eg_if) streak[i] = 0;
            else streak[i] = if_req[i] ? streak[i] + 1 : 0;
            en_at[i]   = c + 1;
            rv_at[i]   = c + 1 + lat_of(i);
            free_at[i] = c + 2 + lat_of(i);
        end
        chk(i, "if_gnt", if_gnt[i], eg_if);
        chk(i, "dm_gnt", dm_gnt[i], eg_dm);
        chk(i, "mem_en", mem_en[i], c == en_at[i]);
        if (c == en_at[i]) begin
            chk(i, "mem_we", mem_we[i], e_we[i]);
            chk(i, "mem_addr", mem_addr[i], e_addr[i]);
            if (e_we[i]) chk(i, "mem_wdata", mem_wdata[i], e_wdata[i]);
        end
        if (c == rv_at[i]) begin
            if (e_dm[i]) x_dmd[i] = e_data[i];
            else x_ifd[i] = e_data[i];
        end
        chk(i, "if_rvalid", if_rvalid[i], (c == rv_at[i]) && !e_dm[i]);
        chk(i, "dm_rvalid", dm_rvalid[i], (c == rv_at[i]) && e_dm[i]);
        chk(i, "if_rdata", if_rdata[i], x_ifd[i]);
        chk(i, "dm_rdata", dm_rdata[i], x_dmd[i]);
        last_ig[i] = if_gnt[i];
        last_dg[i] = dm_gnt[i];
        cyc[i]++;
    endtask

    task automatic tick(input int i);
        @(negedge clk);
        model_check(i);
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1; checks outputs clear asynchronously, releases next cycle.
    task automatic do_reset(input int i);
        rst[i] = 1'b1;
        if_req[i] = 1'b0; dm_req[i] = 1'b0;
        #1;
        chk(i, "rst if_gnt", if_gnt[i], 0);
        chk(i, "rst dm_gnt", dm_gnt[i], 0);
        chk(i, "rst if_rvalid", if_rvalid[i], 0);
        chk(i, "rst dm_rvalid", dm_rvalid[i], 0);
        chk(i, "rst mem_en", mem_en[i], 0);
        chk(i, "rst mem_we", mem_we[i], 0);
        chk(i, "rst mem_addr", mem_addr[i], 0);
        chk(i, "rst mem_wdata", mem_wdata[i], 0);
        chk(i, "rst if_rdata", if_rdata[i], 0);
        chk(i, "rst dm_rdata", dm_rdata[i], 0);
        @(posedge clk);
        #1;
        rst[i] = 1'b0;
        model_reset(i);
    endtask

    task automatic rand_stim(input int i);
        logic [5:0] k;
        if (if_req[i] && last_ig[i]) if_req[i] = 1'b0;
        if (dm_req[i] && last_dg[i]) dm_req[i] = 1'b0;
        if (!if_req[i]) begin
            if ($urandom_range(0, 2) == 0) begin
                k = 6'($urandom);
                if_req[i] = 1'b1; if_addr[i] = {24'h0, k, 2'b00};
            end
        end else if ($urandom_range(0, 15) == 0) begin
            if_req[i] = 1'b0;
        end
        if (!dm_req[i]) begin
            if ($urandom_range(0, 2) == 0) begin
                k = 6'($urandom);
                dm_req[i] = 1'b1; dm_addr[i] = {24'h0, k, 2'b00};
                dm_we[i] = 1'($urandom); dm_wdata[i] = $urandom;
            end
        end else if ($urandom_range(0, 15) == 0) begin
            dm_req[i] = 1'b0;
        end
    endtask

    typedef struct {
        logic ir; logic [31:0] ia; logic dr; logic dw; logic [31:0] da; logic [31:0] dd;
        logic ig; logic dg; logic en; logic we; logic [31:0] ma; logic [31:0] mw;
        logic iv; logic dv; logic [31:0] id; logic [31:0] dmd;
    } vec_t;

    vec_t tv [20];

    initial begin
        int dm_before, if_cnt;
        logic seen_if;

        //          ir ia       dr dw da       dd   ig dg en we ma       mw   iv dv id   dmd
        tv[0]  = '{Y, 32'h10, N, N, Z,       Z,   Y, N, N, N, Z,       Z,   N, N, Z,   Z};
        tv[1]  = '{N, Z,       N, N, Z,       Z,   N, N, Y, N, 32'h10, Z,   N, N, Z,   Z};
        tv[2]  = '{N, Z,       N, N, Z,       Z,   N, N, N, N, Z,       Z,   Y, N, IF0, Z};
        tv[3]  = '{Y, 32'h20, Y, N, 32'h40, Z,   N, Y, N, N, Z,       Z,   N, N, IF0, Z};
        tv[4]  = '{Y, 32'h20, N, N, Z,       Z,   N, N, Y, N, 32'h40, Z,   N, N, IF0, Z};
        tv[5]  = '{Y, 32'h20, N, N, Z,       Z,   N, N, N, N, Z,       Z,   N, Y, IF0, D40};
        tv[6]  = '{Y, 32'h20, N, N, Z,       Z,   Y, N, N, N, Z,       Z,   N, N, IF0, D40};
        tv[7]  = '{N, Z,       N, N, Z,       Z,   N, N, Y, N, 32'h20, Z,   N, N, IF0, D40};
        tv[8]  = '{N, Z,       N, N, Z,       Z,   N, N, N, N, Z,       Z,   Y, N, IF1, D40};
        tv[9]  = '{N, Z,       Y, Y, 32'h44, DB,  N, Y, N, N, Z,       Z,   N, N, IF1, D40};
        tv[10] = '{N, Z,       N, N, Z,       Z,   N, N, Y, Y, 32'h44, DB,  N, N, IF1, D40};
        tv[11] = '{N, Z,       N, N, Z,       Z,   N, N, N, N, Z,       Z,   N, Y, IF1, Z};
        tv[12] = '{N, Z,       Y, N, 32'h44, Z,   N, Y, N, N, Z,       Z,   N, N, IF1, Z};
        tv[13] = '{N, Z,       N, N, Z,       Z,   N, N, Y, N, 32'h44, Z,   N, N, IF1, Z};
        tv[14] = '{N, Z,       N, N, Z,       Z,   N, N, N, N, Z,       Z,   N, Y, IF1, DB};
        tv[15] = '{N, Z,       Y, N, 32'h00, Z,   N, Y, N, N, Z,       Z,   N, N, IF1, DB};
        tv[16] = '{Y, 32'h20, N, N, Z,       Z,   N, N, Y, N, 32'h00, Z,   N, N, IF1, DB};
        tv[17] = '{N, Z,       N, N, Z,       Z,   N, N, N, N, Z,       Z,   N, Y, IF1, D00};
        tv[18] = '{N, Z,       N, N, Z,       Z,   N, N, N, N, Z,       Z,   N, N, IF1, D00};
        tv[19] = '{N, Z,       N, N, Z,       Z,   N, N, N, N, Z,       Z,   N, N, IF1, D00};

        mem_clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; if_req[i] = 1'b0; dm_req[i] = 1'b0; dm_we[i] = 1'b0;
            if_addr[i] = '0; dm_addr[i] = '0; dm_wdata[i] = '0;
            last_ig[i] = 1'b0; last_dg[i] = 1'b0;
            for (int k = 0; k < 64; k++) ref_mem[i][k] = init_word(6'(k));
            model_reset(i);
        end
        @(posedge clk);
        #1;
        mem_clr = 1'b0;
        do_reset(1);
        do_reset(0);

        // Directed vectors on the MEM_LAT=1 instance.
        for (int r = 0; r < 20; r++) begin
            if_req[0] = tv[r].ir; if_addr[0] = tv[r].ia;
            dm_req[0] = tv[r].dr; dm_we[0] = tv[r].dw;
            dm_addr[0] = tv[r].da; dm_wdata[0] = tv[r].dd;
            @(negedge clk);
            chk(0, $sformatf("v%0d if_gnt", r), if_gnt[0], tv[r].ig);
            chk(0, $sformatf("v%0d dm_gnt", r), dm_gnt[0], tv[r].dg);
            chk(0, $sformatf("v%0d mem_en", r), mem_en[0], tv[r].en);
            if (tv[r].en) begin
                chk(0, $sformatf("v%0d mem_we", r), mem_we[0], tv[r].we);
                chk(0, $sformatf("v%0d mem_addr", r), mem_addr[0], tv[r].ma);
                if (tv[r].we) chk(0, $sformatf("v%0d mem_wdata", r), mem_wdata[0], tv[r].mw);
            end
            chk(0, $sformatf("v%0d if_rvalid", r), if_rvalid[0], tv[r].iv);
            chk(0, $sformatf("v%0d dm_rvalid", r), dm_rvalid[0], tv[r].dv);
            chk(0, $sformatf("v%0d if_rdata", r), if_rdata[0], tv[r].id);
            chk(0, $sformatf("v%0d dm_rdata", r), dm_rdata[0], tv[r].dmd);
            @(posedge clk);
            #1;
        end
        ref_mem[0][17] = DB;

        // Randomized traffic against the reference model, both latencies.
        for (int i = 0; i < 2; i++) begin
            do_reset(i);
            for (int n = 0; n < 400; n++) begin
                rand_stim(i);
                tick(i);
            end
        end

        // Fetch held against continuously held data requests.
        do_reset(0);
        if_req[0] = 1'b1; if_addr[0] = 32'h20;
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h40;
        dm_before = 0; if_cnt = 0; seen_if = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick(0);
            if (last_ig[0]) begin
                if_cnt++; seen_if = 1'b1; if_req[0] = 1'b0;
            end
            if (last_dg[0] && !seen_if) dm_before++;
        end
        dm_req[0] = 1'b0;
`ifdef MEM_ARBITER_STARVE_GUARD_EN
        chk(0, "dm grants before fetch", dm_before, MAXS);
        chk(0, "fetch grants", if_cnt, 1);
`else
        chk(0, "fetch grants while dm held", if_cnt, 0);
        chk(0, "dm grants while dm held", dm_before, 14);
`endif

        // Reset during RESP on the MEM_LAT=3 instance.
        do_reset(1);
        dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = 32'h40;
        tick(1);
        dm_req[1] = 1'b0;
        tick(1);
        tick(1);
        do_reset(1);
        for (int n = 0; n < 8; n++) tick(1);
        if_req[1] = 1'b1; if_addr[1] = 32'h10;
        tick(1);
        if_req[1] = 1'b0;
        for (int n = 0; n < 6; n++) tick(1);
        chk(1, "fetch data after reset", if_rdata[1], ref_mem[1][4]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
